// File: rtl/status_display_scanner_if.sv
// Status inputs and display drive bundle for the 4-digit scanner.
interface status_display_scanner_if;
    logic [1:0] encoded_water;
    logic       conflicting_values;
    logic       splinker_bomb;
    logic       dripper_valvule;
    logic       water_supply_valvule;
    logic       segment_a, segment_b, segment_c, segment_d;
    logic       segment_e, segment_f, segment_g;
    logic       displays_point;
    logic       display_3, display_2, display_1, display_0;

    // Control side: produces status, watches the display
    modport master (
        output encoded_water, conflicting_values, splinker_bomb,
               dripper_valvule, water_supply_valvule,
        input  segment_a, segment_b, segment_c, segment_d,
               segment_e, segment_f, segment_g,
               displays_point, display_3, display_2, display_1, display_0
    );

    // Scanner side: consumes status, drives the display
    modport slave (
        input  encoded_water, conflicting_values, splinker_bomb,
               dripper_valvule, water_supply_valvule,
        output segment_a, segment_b, segment_c, segment_d,
               segment_e, segment_f, segment_g,
               displays_point, display_3, display_2, display_1, display_0
    );
endinterface

// File: rtl/status_display_scanner.sv
// Time-multiplexed common-anode 4-digit 7-segment driver for irrigation status.
// Status is snapshotted once per frame; all outputs are registered and active-low.
module status_display_scanner #(
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_STEPS = 250
) (
    input  logic                    clock,
    input  logic                    reset,
    status_display_scanner_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;

    // Lit-segment masks, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] G_0 = 7'b1111110;
    localparam logic [6:0] G_1 = 7'b0110000;
    localparam logic [6:0] G_2 = 7'b1101101;
    localparam logic [6:0] G_3 = 7'b1111001;
    localparam logic [6:0] G_E = 7'b1001111;
    localparam logic [6:0] G_R = 7'b0000101;
    localparam logic [6:0] G_S = 7'b1011011;
    localparam logic [6:0] G_P = 7'b1100111;
    localparam logic [6:0] G_D = 7'b0111101;
    localparam logic [6:0] G_M = 7'b0000001;
    localparam logic [6:0] G_B = 7'b0000000;

    logic [PW-1:0] presc_q;
    logic [1:0]    idx_q;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_phase_q;
    logic [5:0]    snap_q;
    logic          load_pending_q;   // first edge after reset must load the snapshot

    logic [5:0]    in_vec, snap_use;
    logic          step, err;
    logic [6:0]    mask_n;
    logic [3:0]    en_n;
    logic          dp_n;

    logic [6:0]    seg_q;
    logic [3:0]    en_q;
    logic          dp_q;

    assign in_vec = {bus.encoded_water, bus.conflicting_values, bus.splinker_bomb,
                     bus.dripper_valvule, bus.water_supply_valvule};
    assign step   = (presc_q == PW'(SCAN_DIV - 1));

    // Scan timing, digit rotation, blink and frame snapshot state
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q        <= '0;
            idx_q          <= 2'd3;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            snap_q         <= '0;
            load_pending_q <= 1'b1;
        end else begin
            load_pending_q <= 1'b0;
            if (load_pending_q || (step && idx_q == 2'd0))
                snap_q <= in_vec;
            if (step) begin
                presc_q <= '0;
                idx_q   <= idx_q - 1'b1;
                if (blink_cnt_q == BW'(BLINK_STEPS - 1)) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    // Glyph, enable and point for the digit currently indexed. On the load edge
    // the live inputs stand in for the snapshot so the first digit is fresh.
    always_comb begin
        snap_use = load_pending_q ? in_vec : snap_q;
        err      = snap_use[3] | (snap_use[2] & snap_use[1]);
        mask_n   = G_B;
        case (idx_q)
            2'd3: begin
                if (err) mask_n = G_E;
                else case (snap_use[5:4])
                    2'd0:    mask_n = G_0;
                    2'd1:    mask_n = G_1;
                    2'd2:    mask_n = G_2;
                    default: mask_n = G_3;
                endcase
            end
            2'd2:    mask_n = err ? G_R : G_B;
            2'd1:    mask_n = err ? G_R : snap_use[2] ? G_S : snap_use[1] ? G_D : G_M;
            default: mask_n = err ? G_B : snap_use[2] ? G_P : snap_use[1] ? G_R : G_M;
        endcase
        en_n = 4'b1111;
        if (!(err && blink_phase_q))
            en_n[idx_q] = 1'b0;
        dp_n = ~((idx_q == 2'd3) & snap_use[0] & ~err);
    end

    // Registered active-low outputs; dark while in reset
    always_ff @(posedge clock) begin
        if (reset) begin
            seg_q <= '1;
            en_q  <= '1;
            dp_q  <= 1'b1;
        end else begin
            seg_q <= ~mask_n;
            en_q  <= en_n;
            dp_q  <= dp_n;
        end
    end

    assign bus.segment_a      = seg_q[6];
    assign bus.segment_b      = seg_q[5];
    assign bus.segment_c      = seg_q[4];
    assign bus.segment_d      = seg_q[3];
    assign bus.segment_e      = seg_q[2];
    assign bus.segment_f      = seg_q[1];
    assign bus.segment_g      = seg_q[0];
    assign bus.displays_point = dp_q;
    assign bus.display_3      = en_q[3];
    assign bus.display_2      = en_q[2];
    assign bus.display_1      = en_q[1];
    assign bus.display_0      = en_q[0];
endmodule

// File: tb/tb_status_display_scanner.sv
// Directed bench for status_display_scanner with SCAN_DIV=4, BLINK_STEPS=8.
module tb_status_display_scanner;
    localparam int SD = 4;
    localparam int BS = 8;

    localparam logic [6:0] G0 = 7'b1111110;
    localparam logic [6:0] G1 = 7'b0110000;
    localparam logic [6:0] G2 = 7'b1101101;
    localparam logic [6:0] G3 = 7'b1111001;
    localparam logic [6:0] GE = 7'b1001111;
    localparam logic [6:0] GR = 7'b0000101;
    localparam logic [6:0] GS = 7'b1011011;
    localparam logic [6:0] GP = 7'b1100111;
    localparam logic [6:0] GD = 7'b0111101;
    localparam logic [6:0] GM = 7'b0000001;
    localparam logic [6:0] GB = 7'b0000000;

    logic clock;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    status_display_scanner_if bus();

    status_display_scanner #(.SCAN_DIV(SD), .BLINK_STEPS(BS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [11:0] obs();
        return {bus.display_3, bus.display_2, bus.display_1, bus.display_0,
                bus.segment_a, bus.segment_b, bus.segment_c, bus.segment_d,
                bus.segment_e, bus.segment_f, bus.segment_g, bus.displays_point};
    endfunction

    task automatic chk(input string tag, input logic [11:0] o, input logic [11:0] e);
        n_total++;
        assert (o === e) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // n cycles with digit d lit showing mask m, point level dp
    task automatic expect_digit(input string tag, input int d, input logic [6:0] m,
                                input logic dp, input int n);
        logic [3:0] en;
        en    = 4'b1111;
        en[d] = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("%s_d%0d_c%0d", tag, d, i), obs(), {en, ~m, dp});
        end
    endtask

    // n cycles with every enable high (segments don't care)
    task automatic expect_dark(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("%s_c%0d", tag, i), {obs() & 12'hF00}, 12'hF00);
        end
    endtask

    task automatic frame(input string tag, input logic [6:0] m3, input logic [6:0] m2,
                         input logic [6:0] m1, input logic [6:0] m0, input logic dp3);
        expect_digit(tag, 3, m3, dp3, SD);
        expect_digit(tag, 2, m2, 1'b1, SD);
        expect_digit(tag, 1, m1, 1'b1, SD);
        expect_digit(tag, 0, m0, 1'b1, SD);
    endtask

    initial begin
        reset                    = 1'b1;
        bus.encoded_water        = 2'b11;
        bus.conflicting_values   = 1'b0;
        bus.splinker_bomb        = 1'b0;
        bus.dripper_valvule      = 1'b0;
        bus.water_supply_valvule = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_dark", obs(), 12'hFFF);

        // Level mid with sprinkler: "2", blank, "S", "P"
        bus.encoded_water        = 2'b10;
        bus.splinker_bomb        = 1'b1;
        bus.water_supply_valvule = 1'b0;
        reset                    = 1'b0;
        frame("f0", G2, GB, GS, GP, 1'b1);

        // Mid-frame level change stays hidden until the next frame
        expect_digit("f1", 3, G2, 1'b1, 2);
        bus.encoded_water = 2'b11;
        expect_digit("f1b", 3, G2, 1'b1, 2);
        expect_digit("f1", 2, GB, 1'b1, SD);
        expect_digit("f1", 1, GS, 1'b1, SD);
        expect_digit("f1", 0, GP, 1'b1, SD);

        // New level visible; switch to dripper + supply before the reload edge
        expect_digit("f2", 3, G3, 1'b1, SD);
        expect_digit("f2", 2, GB, 1'b1, SD);
        expect_digit("f2", 1, GS, 1'b1, SD);
        bus.encoded_water        = 2'b00;
        bus.splinker_bomb        = 1'b0;
        bus.dripper_valvule      = 1'b1;
        bus.water_supply_valvule = 1'b1;
        expect_digit("f2", 0, GP, 1'b1, SD);

        // "0" with point, blank, "d", "r"; then raise the conflict flag
        expect_digit("f3", 3, G0, 1'b0, SD);
        expect_digit("f3", 2, GB, 1'b1, SD);
        expect_digit("f3", 1, GD, 1'b1, SD);
        bus.conflicting_values = 1'b1;
        expect_digit("f3", 0, GR, 1'b1, SD);

        // Error: lit for 8 steps, dark for 8, lit again; point suppressed
        frame("f4", GE, GR, GR, GB, 1'b1);
        frame("f5", GE, GR, GR, GB, 1'b1);
        expect_dark("f67", 8 * SD);
        expect_digit("f8", 3, GE, 1'b1, SD);
        expect_digit("f8", 2, GR, 1'b1, SD);
        expect_digit("f8", 1, GR, 1'b1, SD);
        bus.conflicting_values = 1'b0;
        bus.splinker_bomb      = 1'b1;
        bus.dripper_valvule    = 1'b1;
        expect_digit("f8", 0, GB, 1'b1, SD);

        // Sprinkler + dripper is the same error display, same blink cadence
        frame("f9", GE, GR, GR, GB, 1'b1);
        expect_dark("f10", 3 * SD);
        bus.encoded_water        = 2'b01;
        bus.splinker_bomb        = 1'b0;
        bus.dripper_valvule      = 1'b0;
        bus.water_supply_valvule = 1'b0;
        expect_dark("f10b", SD);

        // Clearance: normal mode lit even though blink phase is 1;
        // a conflict pulse between reload edges is never shown
        expect_digit("f11", 3, G1, 1'b1, SD);
        bus.conflicting_values = 1'b1;
        expect_digit("f11", 2, GB, 1'b1, SD);
        bus.conflicting_values = 1'b0;
        expect_digit("f11", 1, GM, 1'b1, SD);
        expect_digit("f11", 0, GM, 1'b1, SD);

        // Reset in the middle of display_1
        expect_digit("f12", 3, G1, 1'b1, SD);
        expect_digit("f12", 2, GB, 1'b1, SD);
        expect_digit("f12", 1, GM, 1'b1, 2);
        reset                    = 1'b1;
        bus.encoded_water        = 2'b11;
        bus.splinker_bomb        = 1'b1;
        bus.water_supply_valvule = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("midreset_dark", obs(), 12'hFFF);
        reset = 1'b0;
        frame("f13", G3, GB, GS, GP, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
